// File: rtl/iob_cache_pkg.sv
// Shared types and reset constants for the cache back-end arbiter.
package iob_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  // Pointer starts at requester 1 so requester 0 wins the first tie.
  localparam logic RST_LAST_GRANT = 1'b1;
  localparam logic RST_GRANT      = 1'b0;

endpackage

// File: rtl/iob_cache_be_arbiter_if.sv
// Requester and back-end bus bundle for iob_cache_be_arbiter; slave = arbiter view.
interface iob_cache_be_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int NBYTES = DATA_W / 8;

  logic              r0_avalid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [NBYTES-1:0] r0_wstrb;
  logic              r0_ready;
  logic [DATA_W-1:0] r0_rdata;
  logic              r0_rvalid;

  logic              r1_avalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic [NBYTES-1:0] r1_wstrb;
  logic              r1_ready;
  logic [DATA_W-1:0] r1_rdata;
  logic              r1_rvalid;

  logic              be_avalid;
  logic [ADDR_W-1:0] be_addr;
  logic [DATA_W-1:0] be_wdata;
  logic [NBYTES-1:0] be_wstrb;
  logic [DATA_W-1:0] be_rdata;
  logic              be_rvalid;
  logic              be_ready;

  modport slave (
    input  r0_avalid, r0_addr, r0_wdata, r0_wstrb,
    output r0_ready, r0_rdata, r0_rvalid,
    input  r1_avalid, r1_addr, r1_wdata, r1_wstrb,
    output r1_ready, r1_rdata, r1_rvalid,
    output be_avalid, be_addr, be_wdata, be_wstrb,
    input  be_rdata, be_rvalid, be_ready
  );

  modport master (
    output r0_avalid, r0_addr, r0_wdata, r0_wstrb,
    input  r0_ready, r0_rdata, r0_rvalid,
    output r1_avalid, r1_addr, r1_wdata, r1_wstrb,
    input  r1_ready, r1_rdata, r1_rvalid,
    input  be_avalid, be_addr, be_wdata, be_wstrb,
    output be_rdata, be_rvalid, be_ready
  );

endinterface

// File: rtl/iob_cache_rr_arb.sv
// Two-input arbiter with a registered last-grant pointer.
// IOB_CACHE_BE_ARB_FIXED_PRIO_EN: ties always go to requester 0, no pointer.
module iob_cache_rr_arb
  import iob_cache_pkg::*;
(
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       cke_i,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_grant
);

`ifdef IOB_CACHE_BE_ARB_FIXED_PRIO_EN
  assign o_grant = ~i_req[0];

  wire w_unused = &{1'b0, clk_i, arst_n_i, cke_i, i_take, i_req[1]};
`else
  logic r_last;

  // A lone requester wins; a tie goes to whoever was not granted last.
  always_comb begin
    o_grant = ~i_req[0];
    if (&i_req) o_grant = ~r_last;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)             r_last <= RST_LAST_GRANT;
    else if (cke_i && i_take)  r_last <= o_grant;
  end
`endif

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Shares one cache back-end port between two requesters (FSM + payload mux).
// Tie policy selected by IOB_CACHE_BE_ARB_FIXED_PRIO_EN inside iob_cache_rr_arb.
//
// state  | meaning
// IDLE   | no owner; registers the arbitration winner when any request is valid
// REQ    | be_avalid driven from the owner until the back-end accepts
// RDWAIT | read accepted, waiting for be_rvalid to return data to the owner
module iob_cache_be_arbiter
  import iob_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   cke_i,
  iob_cache_be_arbiter_if.slave  bus,
  output logic                   grant_o,
  output logic                   busy_o
);

  localparam int NBYTES = DATA_W / 8;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_grant;
  logic              w_arb_grant;
  logic              w_take;
  logic              w_be_avalid;
  logic              w_ready;
  logic              w_rvalid;
  logic [1:0]        w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [NBYTES-1:0] w_wstrb;

  assign w_req = {bus.r1_avalid, bus.r0_avalid};

  iob_cache_rr_arb u_rr_arb (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .i_req    (w_req),
    .i_take   (w_take),
    .o_grant  (w_arb_grant)
  );

  always_comb begin
    w_addr  = bus.r0_addr;
    w_wdata = bus.r0_wdata;
    w_wstrb = bus.r0_wstrb;
    if (r_grant) begin
      w_addr  = bus.r1_addr;
      w_wdata = bus.r1_wdata;
      w_wstrb = bus.r1_wstrb;
    end
  end

  // Handshake pulses are qualified by cke_i so a stalled cycle never acknowledges.
  always_comb begin
    w_state_nxt = r_state;
    w_be_avalid = 1'b0;
    w_ready     = 1'b0;
    w_rvalid    = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_take      = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_be_avalid = 1'b1;
        if (bus.be_ready && cke_i) begin
          w_ready     = 1'b1;
          w_state_nxt = (|w_wstrb) ? IDLE : RDWAIT;
        end
      end
      RDWAIT: begin
        if (bus.be_rvalid && cke_i) begin
          w_rvalid    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
      r_grant <= RST_GRANT;
    end else if (cke_i) begin
      r_state <= w_state_nxt;
      if (w_take) r_grant <= w_arb_grant;
    end
  end

  assign bus.be_avalid = w_be_avalid;
  assign bus.be_addr   = w_addr;
  assign bus.be_wdata  = w_wdata;
  assign bus.be_wstrb  = w_wstrb;

  assign bus.r0_ready  = w_ready  & ~r_grant;
  assign bus.r1_ready  = w_ready  &  r_grant;
  assign bus.r0_rvalid = w_rvalid & ~r_grant;
  assign bus.r1_rvalid = w_rvalid &  r_grant;
  assign bus.r0_rdata  = bus.be_rdata;
  assign bus.r1_rdata  = bus.be_rdata;

  assign grant_o = r_grant;
  assign busy_o  = (r_state != IDLE);

endmodule

// File: doc/iob_cache_be_arbiter.md
IOB_CACHE_BE_ARBITER -- requirements
Module: iob_cache_be_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, back-end byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, back-end data width; NBYTES = DATA_W/8.
REQ-003 SHALL have port clk_i  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port arst_n_i  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cke_i  in  1  clock enable; when low, all state holds.
REQ-006 SHALL have ports r0_avalid/r1_avalid  in  1  request valid from requesters 0 and 1.
REQ-007 SHALL have ports r0_addr/r1_addr  in  ADDR_W  request address.
REQ-008 SHALL have ports r0_wdata/r1_wdata  in  DATA_W  write data.
REQ-009 SHALL have ports r0_wstrb/r1_wstrb  in  NBYTES  write strobe; all-zero means read.
REQ-010 SHALL have ports r0_ready/r1_ready  out  1  request accepted.
REQ-011 SHALL have ports r0_rdata/r1_rdata  out  DATA_W  read data.
REQ-012 SHALL have ports r0_rvalid/r1_rvalid  out  1  read data valid.
REQ-013 SHALL have ports be_avalid/be_addr/be_wdata/be_wstrb  out  1/ADDR_W/DATA_W/NBYTES  shared back-end request.
REQ-014 SHALL have ports be_rdata/be_rvalid/be_ready  in  DATA_W/1/1  back-end response.
REQ-015 SHALL have port grant_o  out  1  index of the owning requester, valid when busy_o is high.
REQ-016 SHALL have port busy_o  out  1  transaction in progress.

Function
REQ-017 SHALL implement an FSM with states IDLE, REQ and RDWAIT.
REQ-018 IDLE: if either avalid is high, SHALL register the winner into grant_o and go to REQ; otherwise SHALL stay in IDLE.
REQ-019 Round-robin: when both requesters are valid in IDLE, SHALL grant the requester not granted last; a lone requester always wins.
REQ-020 REQ: SHALL drive be_avalid=1 with be_addr/be_wdata/be_wstrb muxed combinationally from the granted requester.
REQ-021 REQ with be_ready=1: SHALL pulse the granted rN_ready for that cycle; write goes to IDLE, read goes to RDWAIT.
REQ-022 RDWAIT: be_avalid=0; on be_rvalid=1, SHALL assert the granted rN_rvalid the same cycle and go to IDLE.
REQ-023 rN_rdata SHALL equal be_rdata for both requesters; only the granted requester's rvalid may assert.
REQ-024 The non-granted requester's ready and rvalid SHALL stay 0 throughout a transaction.
REQ-025 Minimum latency: avalid at cycle 0, be_avalid at cycle 1; with be_ready at cycle 1, rN_ready at cycle 1.
REQ-026 Requesters SHALL hold avalid and payload stable until ready; a deassertion in REQ is ignored until the back-end accepts.
REQ-027 be_rvalid outside RDWAIT SHALL be ignored.
REQ-028 busy_o SHALL be high in REQ and RDWAIT.
REQ-029 After a transaction completes, a new grant SHALL take at least one IDLE cycle, so there are no back-to-back be_avalid cycles across owners.

Reset
REQ-030 While arst_n_i is low: state=IDLE; last-granted pointer=1, so requester 0 wins the first tie; grant_o=0; be_avalid, busy_o, rN_ready and rN_rvalid all 0.
REQ-031 A reset mid-transaction SHALL abandon it with no ready or rvalid issued.

Configuration
REQ-032 Macro IOB_CACHE_BE_ARB_FIXED_PRIO_EN defined: a tie SHALL always grant requester 0, and the round-robin pointer is not implemented.
REQ-033 Macro undefined: REQ-019 round-robin applies.

Structure
REQ-034 The shared package iob_cache_pkg SHALL hold the FSM state enum (IDLE/REQ/RDWAIT) and the constants for the reset grant pointer.
REQ-035 A sub-module iob_cache_rr_arb (2-input arbiter, registered pointer, macro-controlled) SHALL be used; the FSM and mux stay in the top module.

Verification
REQ-036 r0 read at addr 0x100, be_ready at cycle 1, be_rdata 0xDEADBEEF with be_rvalid at cycle 3 -> r0_ready at cycle 1, r0_rvalid at cycle 3 with 0xDEADBEEF, r1 outputs 0.
REQ-037 r0 and r1 both issue writes continuously -> grants alternate 0,1,0,1 (macro off); macro on -> requester 0 wins every tie.
REQ-038 r1 write wstrb 0xF, be_ready held low 5 cycles -> be_avalid held with r1 payload, r1_ready pulses exactly once when be_ready rises.
REQ-039 Spurious be_rvalid during IDLE and REQ -> no rN_rvalid.
REQ-040 arst_n_i low during RDWAIT -> next cycle IDLE, all outputs 0; the following r1 request is served normally.
